rv_bus_arb: RTL and testbench
=============================

// Module: rv_bus_arb
// PURPOSE
// - Parametrised bus unit: arbitrates NCH requesters (ch0 = fetch, ch1 = load/store, extra = DMA/debug) onto the CPU's single external bus.
// - Bus signals: ads / rd_wr_n / i_dn / addr / be / wr_data / rd_data / ack.
// - Sits between the fetch-decode/ALU side and the memory system.
// - Also registers the external intr into a sync'd flag.
// PARAMETERS
// NCH        2   number of request channels (1..8)
// AW         32  address width
// DW         32  data width (multiple of 8); BE width = DW/8
// PRIO_MODE  0   0 = round-robin, 1 = fixed priority (lowest index wins)
// TO_CYC     256 ack timeout in cycles, >=2 (used only with RV_BUS_TIMEOUT_EN)
// PORTS
// clk          in   1            clock
// reset        in   1            synchronous, active-high reset
// req_valid    in   NCH          per-channel request pending
// req_ready    out  NCH          one-hot one-cycle accept pulse
// req_addr     in   NCH x AW     per-channel address
// req_be       in   NCH x DW/8   per-channel byte enables
// req_wdata    in   NCH x DW     per-channel write data
// req_rd_wr_n  in   NCH          1 = read, 0 = write
// req_i_dn     in   NCH          1 = instruction, 0 = data
// rsp_valid    out  NCH          one-hot one-cycle completion pulse
// rsp_data     out  DW           read data, valid with rsp_valid
// rsp_err      out  1            timeout error, valid with rsp_valid
// ads rd_wr_n i_dn  out 1 each   bus address strobe / direction / type
// addr wr_data be   out AW/DW/DW8 bus address, write data, byte enables
// rd_data      in   DW           bus read data, sampled with ack
// ack          in   1            bus completion
// intr         in   1            async interrupt request
// intr_sync    out  1            2-flop synchronised intr
// BEHAVIOUR
// - Reset: FSM = IDLE; rr_ptr = 0; all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_err, ads, rd_wr_n, i_dn, addr, be, wr_data, intr_sync).
// - FSM states IDLE -> ADDR -> WAIT -> IDLE.
// - IDLE: if |req_valid, pick g and latch channel g's fields.
//   - Same cycle: req_ready[g] = 1 (combinational, one cycle). Next state ADDR.
// - ADDR: ads = 1 for exactly this cycle; addr/be/wr_data/rd_wr_n/i_dn driven from latch.
//   - Bus fields stay held through WAIT and return to 0 in IDLE.
//   - ack is sampled in ADDR too (zero-wait slave).
// - WAIT: hold until ack = 1.
// - On ack (ADDR or WAIT):
//   - next cycle rsp_valid[g] = 1, rsp_data = rd_data (reads; 0 for writes), rsp_err = 0;
//   - FSM -> IDLE.
// - Latency: accept at T, ads at T+1, earliest rsp_valid at T+2. New grant allowed in the same cycle rsp_valid is high.
// - ack while in IDLE is ignored; no rsp generated.
// - Arbitration:
//   - PRIO_MODE 0: search starts at rr_ptr; after granting g, rr_ptr = (g+1) mod NCH.
//   - PRIO_MODE 1: lowest set index wins.
//   - NCH = 1: always grant 0.
// - Requesters hold req_* stable until req_ready. Deasserting req_valid before accept is legal (no transaction).
// - Reset mid-transaction: abort, no rsp pulse, ads low from the next cycle.
// - intr_sync = intr delayed through 2 flops.
// CONFIGURATION
// - `RV_BUS_TIMEOUT_EN` defined:
//   - cycle counter clears on entering ADDR;
//   - if TO_CYC cycles elapse in ADDR+WAIT without ack: rsp_valid[g] = 1, rsp_err = 1, rsp_data = 0, FSM -> IDLE;
//   - a later stray ack is ignored.
// - Undefined: no counter; WAIT lasts until ack; rsp_err is tied to 0.
// STRUCTURE
// - Package rv_bus_pkg: typedef enum logic [1:0] bus_state_t {IDLE, ADDR, WAIT}; localparams I_FETCH = 1'b1, D_ACCESS = 1'b0, RD = 1'b1, WR = 1'b0.
// - Sub-module rv_rr_arb: combinational NCH-way grant.
//   - Inputs: req, ptr, mode. Output: one-hot grant plus index.
//   - rr_ptr register lives in rv_bus_arb.
// TESTING
// - Single read ch0, addr 0x0000_0100; ack 2 cycles after ads with rd_data 0xDEAD_BEEF:
//   - ads 1 cycle, i_dn = 1, rd_wr_n = 1;
//   - rsp_valid[0] 1 cycle later with rsp_data 0xDEAD_BEEF.
// - Write ch1, addr 0x200, be 4'b0011, wdata 0x1234_5678, zero-wait ack in ADDR:
//   - bus shows these values, rd_wr_n = 0;
//   - rsp_valid[1] at T+2.
// - NCH=3, PRIO_MODE 0, all three valid continuously for 6 transactions: grant order 0,1,2,0,1,2.
//   - Same stimulus with PRIO_MODE 1: always 0.
// - Reset asserted in WAIT: ads/addr go 0, no rsp_valid.
//   - Next request after reset completes normally, with rr_ptr = 0.
// - `RV_BUS_TIMEOUT_EN`, TO_CYC = 8, no ack: rsp_valid = 1 with rsp_err = 1, rsp_data = 0, 8 cycles after ADDR.
//   - Late ack is ignored.
// - intr pulse of 3 cycles: intr_sync high for 3 cycles, starting 2 cycles later.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared types and constants for the rv_bus_arb bus unit.
package rv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } bus_state_t;

  // Encodings of the bus type/direction qualifiers
  localparam logic I_FETCH  = 1'b1;
  localparam logic D_ACCESS = 1'b0;
  localparam logic RD       = 1'b1;
  localparam logic WR       = 1'b0;

  // Width of a channel index; at least one bit even for a single channel
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_rr_arb.sv
// Combinational NCH-way arbiter: round-robin from ptr (mode 0) or
// fixed priority with lowest index winning (mode 1).
module rv_rr_arb
  import rv_bus_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           mode,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_idx,
  output logic           grant_any
);

  // Scan NCH channels starting at the search origin, first set request wins
  always_comb begin
    int start_idx;
    int cur_idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    start_idx = mode ? 0 : int'(ptr);
    if (start_idx >= NCH) start_idx = 0;
    for (int i = 0; i < NCH; i++) begin
      cur_idx = start_idx + i;
      if (cur_idx >= NCH) cur_idx = cur_idx - NCH;
      if (!grant_any && req[cur_idx]) begin
        grant_any      = 1'b1;
        grant_idx      = IW'(cur_idx);
        grant[cur_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_bus_arb.sv
// Bus unit: arbitrates NCH requesters onto one external bus with an
// IDLE -> ADDR -> WAIT -> IDLE handshake, and synchronises intr.
// Optional feature macro: RV_BUS_TIMEOUT_EN (ack timeout after TO_CYC
// cycles, reported through rsp_err); without it rsp_err is always 0.
module rv_bus_arb
  import rv_bus_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TO_CYC    = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           req_valid,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH-1:0][AW-1:0]   req_addr,
  input  logic [NCH-1:0][DW/8-1:0] req_be,
  input  logic [NCH-1:0][DW-1:0]   req_wdata,
  input  logic [NCH-1:0]           req_rd_wr_n,
  input  logic [NCH-1:0]           req_i_dn,
  output logic [NCH-1:0]           rsp_valid,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic                     ads,
  output logic                     rd_wr_n,
  output logic                     i_dn,
  output logic [AW-1:0]            addr,
  output logic [DW-1:0]            wr_data,
  output logic [DW/8-1:0]          be,
  input  logic [DW-1:0]            rd_data,
  input  logic                     ack,
  input  logic                     intr,
  output logic                     intr_sync
);

  localparam int IW = idx_w(NCH);
  localparam int BW = DW / 8;

  if (NCH < 1 || NCH > 8 || (DW % 8) != 0 || TO_CYC < 2) begin : g_bad_params
    $error("rv_bus_arb: illegal parameter combination");
  end

  bus_state_t     state_reg;
  logic [IW-1:0]  rr_ptr_reg;
  logic [IW-1:0]  rr_ptr_next;
  logic [NCH-1:0] gnt_reg;
  logic           ads_reg;
  logic           rd_wr_n_reg;
  logic           i_dn_reg;
  logic [AW-1:0]  addr_reg;
  logic [BW-1:0]  be_reg;
  logic [DW-1:0]  wr_data_reg;
  logic [NCH-1:0] rsp_valid_reg;
  logic [DW-1:0]  rsp_data_reg;
  logic           intr_meta_reg;
  logic           intr_sync_reg;

  logic [NCH-1:0] grant;
  logic [IW-1:0]  grant_idx;
  logic           grant_any;

  logic [AW-1:0]  sel_addr;
  logic [BW-1:0]  sel_be;
  logic [DW-1:0]  sel_wdata;
  logic           sel_rd_wr_n;
  logic           sel_i_dn;

`ifdef RV_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0]  to_cnt_reg;
  logic           rsp_err_reg;
`endif

  rv_rr_arb #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .mode      (PRIO_MODE != 0),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Round-robin pointer moves just past the channel being granted
  assign rr_ptr_next = (int'(grant_idx) >= NCH - 1) ? '0 : grant_idx + 1'b1;

  // Accept pulse only while idle; suppressed while reset is asserted
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign req_ready[gi] = (state_reg == IDLE) && !reset && grant[gi];
  end

  // One-hot mux of the granted channel's request fields
  always_comb begin
    sel_addr    = '0;
    sel_be      = '0;
    sel_wdata   = '0;
    sel_rd_wr_n = 1'b0;
    sel_i_dn    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        sel_addr    = req_addr[i];
        sel_be      = req_be[i];
        sel_wdata   = req_wdata[i];
        sel_rd_wr_n = req_rd_wr_n[i];
        sel_i_dn    = req_i_dn[i];
      end
    end
  end

  // Bus FSM: latch on accept, strobe ads in ADDR, wait for ack, pulse response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      gnt_reg       <= '0;
      ads_reg       <= 1'b0;
      rd_wr_n_reg   <= 1'b0;
      i_dn_reg      <= 1'b0;
      addr_reg      <= '0;
      be_reg        <= '0;
      wr_data_reg   <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
`ifdef RV_BUS_TIMEOUT_EN
      to_cnt_reg    <= '0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
`ifdef RV_BUS_TIMEOUT_EN
      rsp_err_reg   <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            gnt_reg     <= grant;
            rr_ptr_reg  <= rr_ptr_next;
            addr_reg    <= sel_addr;
            be_reg      <= sel_be;
            wr_data_reg <= sel_wdata;
            rd_wr_n_reg <= sel_rd_wr_n;
            i_dn_reg    <= sel_i_dn;
            ads_reg     <= 1'b1;
`ifdef RV_BUS_TIMEOUT_EN
            to_cnt_reg  <= '0;
`endif
            state_reg   <= ADDR;
          end
        end
        ADDR, WAIT: begin
          ads_reg <= 1'b0;
          if (ack) begin
            rsp_valid_reg <= gnt_reg;
            rsp_data_reg  <= (rd_wr_n_reg == RD) ? rd_data : '0;
            addr_reg      <= '0;
            be_reg        <= '0;
            wr_data_reg   <= '0;
            rd_wr_n_reg   <= 1'b0;
            i_dn_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
`ifdef RV_BUS_TIMEOUT_EN
          else if (to_cnt_reg == CW'(TO_CYC - 1)) begin
            // Slave never answered: complete with an error and no data
            rsp_valid_reg <= gnt_reg;
            rsp_err_reg   <= 1'b1;
            addr_reg      <= '0;
            be_reg        <= '0;
            wr_data_reg   <= '0;
            rd_wr_n_reg   <= 1'b0;
            i_dn_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            state_reg  <= WAIT;
          end
`else
          else begin
            state_reg <= WAIT;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_meta_reg <= 1'b0;
      intr_sync_reg <= 1'b0;
    end else begin
      intr_meta_reg <= intr;
      intr_sync_reg <= intr_meta_reg;
    end
  end

  assign ads       = ads_reg;
  assign rd_wr_n   = rd_wr_n_reg;
  assign i_dn      = i_dn_reg;
  assign addr      = addr_reg;
  assign be        = be_reg;
  assign wr_data   = wr_data_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign intr_sync = intr_sync_reg;
`ifdef RV_BUS_TIMEOUT_EN
  assign rsp_err   = rsp_err_reg;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rv_bus_arb.sv
// Directed bench for rv_bus_arb: one round-robin and one fixed-priority
// instance (both NCH=3) share the request stimulus.
module tb_rv_bus_arb;
  import rv_bus_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0]           req_valid = '0;
  logic [NCH-1:0][AW-1:0]   req_addr = '0;
  logic [NCH-1:0][DW/8-1:0] req_be = '0;
  logic [NCH-1:0][DW-1:0]   req_wdata = '0;
  logic [NCH-1:0]           req_rd_wr_n = '0;
  logic [NCH-1:0]           req_i_dn = '0;
  logic [DW-1:0]            rd_data = '0;
  logic                     ack_man = 1'b0;
  logic                     auto_ack = 1'b0;
  logic                     intr = 1'b0;

  logic [NCH-1:0] req_ready_rr, rsp_valid_rr, req_ready_fp, rsp_valid_fp;
  logic [DW-1:0]  rsp_data_rr, rsp_data_fp, wr_data_rr, wr_data_fp;
  logic           rsp_err_rr, rsp_err_fp, ads_rr, ads_fp;
  logic           rd_wr_n_rr, rd_wr_n_fp, i_dn_rr, i_dn_fp;
  logic [AW-1:0]  addr_rr, addr_fp;
  logic [DW/8-1:0] be_rr, be_fp;
  logic           intr_sync_rr, intr_sync_fp;
  logic           ack_rr, ack_fp;

  assign ack_rr = auto_ack ? ads_rr : ack_man;
  assign ack_fp = ads_fp;

  always #5 clk = ~clk;

  rv_bus_arb #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(0), .TO_CYC(8)) u_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_rr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .req_rd_wr_n(req_rd_wr_n), .req_i_dn(req_i_dn), .rsp_valid(rsp_valid_rr),
    .rsp_data(rsp_data_rr), .rsp_err(rsp_err_rr), .ads(ads_rr),
    .rd_wr_n(rd_wr_n_rr), .i_dn(i_dn_rr), .addr(addr_rr), .wr_data(wr_data_rr),
    .be(be_rr), .rd_data(rd_data), .ack(ack_rr), .intr(intr),
    .intr_sync(intr_sync_rr)
  );

  rv_bus_arb #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(1), .TO_CYC(8)) u_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_fp),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .req_rd_wr_n(req_rd_wr_n), .req_i_dn(req_i_dn), .rsp_valid(rsp_valid_fp),
    .rsp_data(rsp_data_fp), .rsp_err(rsp_err_fp), .ads(ads_fp),
    .rd_wr_n(rd_wr_n_fp), .i_dn(i_dn_fp), .addr(addr_fp), .wr_data(wr_data_fp),
    .be(be_fp), .rd_data(rd_data), .ack(ack_fp), .intr(intr),
    .intr_sync(intr_sync_fp)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [NCH-1:0] oh);
    for (int i = 0; i < NCH; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Drive identical fields on every channel with valid = mask; expect grant exp_ch
  task automatic do_txn(input string tag, input logic [NCH-1:0] mask, input int exp_ch,
                        input logic rw, input logic idn, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd, input int dly,
                        input logic [31:0] rdat);
    logic [NCH-1:0] exp_oh;
    exp_oh = NCH'(1) << exp_ch;
    for (int i = 0; i < NCH; i++) begin
      req_addr[i] = a; req_be[i] = b; req_wdata[i] = wd;
      req_rd_wr_n[i] = rw; req_i_dn[i] = idn;
    end
    req_valid = mask;
    ack_man = 1'b0;
    @(negedge clk);
    check({tag, ".req_ready"}, 64'(req_ready_rr), 64'(exp_oh));
    next_cycle();
    req_valid = '0;
    for (int c = 0; c <= dly; c++) begin
      ack_man = (c == dly);
      rd_data = (c == dly) ? rdat : 32'h0;
      @(negedge clk);
      check($sformatf("%s.ads[%0d]", tag, c), 64'(ads_rr), 64'(c == 0));
      check($sformatf("%s.addr[%0d]", tag, c), 64'(addr_rr), 64'(a));
      if (c == 0) begin
        check({tag, ".be"}, 64'(be_rr), 64'(b));
        check({tag, ".wr_data"}, 64'(wr_data_rr), 64'(wd));
        check({tag, ".rd_wr_n"}, 64'(rd_wr_n_rr), 64'(rw));
        check({tag, ".i_dn"}, 64'(i_dn_rr), 64'(idn));
      end
      check($sformatf("%s.no_rsp[%0d]", tag, c), 64'(rsp_valid_rr), 64'(0));
      next_cycle();
    end
    ack_man = 1'b0;
    rd_data = 32'h5555_5555;
    @(negedge clk);
    check({tag, ".rsp_valid"}, 64'(rsp_valid_rr), 64'(exp_oh));
    check({tag, ".rsp_data"}, 64'(rsp_data_rr), 64'(rw ? rdat : 32'h0));
    check({tag, ".rsp_err"}, 64'(rsp_err_rr), 64'(0));
    check({tag, ".bus_idle"}, 64'({ads_rr, addr_rr}), 64'(0));
    $display("txn %s: ch=%0d rw=%0d addr=0x%0h rsp_data=0x%0h", tag, exp_ch, rw, a, rsp_data_rr);
    next_cycle();
  endtask

  typedef struct {
    logic [NCH-1:0] mask;
    int             exp_ch;
    logic           rw;
    logic           idn;
    logic [31:0]    a;
    logic [3:0]     b;
    logic [31:0]    wd;
    int             dly;
    logic [31:0]    rdat;
  } txn_t;

  typedef struct {
    int exp_rr;
    int exp_fp;
  } rot_t;

  txn_t tv[4];
  rot_t rv[6];
  int   got_rr[$];
  int   got_fp[$];

  initial begin
    tv[0] = '{3'b001, 0, RD, I_FETCH,  32'h0000_0100, 4'hF, 32'h0,         2, 32'hDEAD_BEEF};
    tv[1] = '{3'b010, 1, WR, D_ACCESS, 32'h0000_0200, 4'h3, 32'h1234_5678, 0, 32'h0};
    tv[2] = '{3'b100, 2, RD, D_ACCESS, 32'h0000_0300, 4'hC, 32'h0,         1, 32'hCAFE_F00D};
    tv[3] = '{3'b001, 0, WR, D_ACCESS, 32'h0000_0404, 4'h1, 32'hA5A5_A5A5, 3, 32'h1111_1111};
    for (int i = 0; i < 6; i++) rv[i] = '{i % 3, 0};

    // Reset state with requests and intr pending
    reset = 1'b1; req_valid = '1; intr = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset.req_ready", 64'({req_ready_rr, req_ready_fp}), 64'(0));
    check("reset.outputs", 64'({rsp_valid_rr, ads_rr, rd_wr_n_rr, i_dn_rr, rsp_err_rr, intr_sync_rr}), 64'(0));
    check("reset.bus", 64'({addr_rr, be_rr}), 64'(0));
    check("reset.data", 64'({rsp_data_rr, wr_data_rr}), 64'(0));
    $display("txn reset: outputs sampled");
    next_cycle();
    req_valid = '0; intr = 1'b0; reset = 1'b0;
    repeat (3) next_cycle();

    // Table of single transactions
    for (int i = 0; i < 4; i++)
      do_txn($sformatf("tv%0d", i), tv[i].mask, tv[i].exp_ch, tv[i].rw, tv[i].idn,
             tv[i].a, tv[i].b, tv[i].wd, tv[i].dly, tv[i].rdat);

    // Stray ack while idle produces nothing
    ack_man = 1'b1; rd_data = 32'h9999_9999;
    next_cycle();
    ack_man = 1'b0;
    @(negedge clk);
    check("stray_ack.rsp_valid", 64'(rsp_valid_rr), 64'(0));
    check("stray_ack.ads", 64'(ads_rr), 64'(0));
    $display("txn stray_ack: rsp_valid=%b", rsp_valid_rr);
    next_cycle();

    // Reset while waiting for ack on ch1 (rr_ptr would become 2)
    req_addr[1] = 32'h0000_0ABC; req_rd_wr_n[1] = RD; req_valid = 3'b010;
    @(negedge clk);
    check("rst_wait.req_ready", 64'(req_ready_rr), 64'(3'b010));
    next_cycle();
    req_valid = '0;
    next_cycle();
    @(negedge clk);
    check("rst_wait.addr_held", 64'(addr_rr), 64'(32'h0000_0ABC));
    reset = 1'b1;
    next_cycle();
    ack_man = 1'b1; rd_data = 32'h7777_7777;
    @(negedge clk);
    check("rst_wait.ads", 64'(ads_rr), 64'(0));
    check("rst_wait.addr", 64'(addr_rr), 64'(0));
    check("rst_wait.rsp_valid", 64'(rsp_valid_rr), 64'(0));
    next_cycle();
    reset = 1'b0; ack_man = 1'b0;
    @(negedge clk);
    check("rst_wait.no_rsp_after", 64'(rsp_valid_rr), 64'(0));
    $display("txn rst_wait: aborted");
    next_cycle();
    do_txn("post_rst0", 3'b111, 0, RD, D_ACCESS, 32'h0000_0010, 4'hF, 32'h0, 1, 32'h0BAD_F00D);
    do_txn("post_rst1", 3'b111, 1, WR, D_ACCESS, 32'h0000_0020, 4'h8, 32'h0000_00EE, 0, 32'h0);

    // Continuous requests on all channels, zero-wait slave
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; auto_ack = 1'b1; req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready_rr != '0) got_rr.push_back(oh2idx(req_ready_rr));
      if (req_ready_fp != '0) got_fp.push_back(oh2idx(req_ready_fp));
      next_cycle();
    end
    req_valid = '0; auto_ack = 1'b0;
    check("rot.count_rr", 64'(got_rr.size()), 64'(6));
    check("rot.count_fp", 64'(got_fp.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      int grr, gfp;
      grr = (i < got_rr.size()) ? got_rr[i] : -1;
      gfp = (i < got_fp.size()) ? got_fp[i] : -1;
      check($sformatf("rot%0d.rr", i), 64'(grr), 64'(rv[i].exp_rr));
      check($sformatf("rot%0d.fp", i), 64'(gfp), 64'(rv[i].exp_fp));
      $display("txn rot%0d: rr=%0d fp=%0d", i, grr, gfp);
    end
    repeat (2) next_cycle();

`ifdef RV_BUS_TIMEOUT_EN
    // No ack: error response 8 cycles after ADDR, then a late ack is ignored
    req_rd_wr_n[2] = RD; req_addr[2] = 32'h0000_0500; req_valid = 3'b100;
    @(negedge clk);
    check("to.req_ready", 64'(req_ready_rr), 64'(3'b100));
    next_cycle();
    req_valid = '0; rd_data = 32'h7777_7777;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("to.no_rsp[%0d]", c), 64'(rsp_valid_rr), 64'(0));
      next_cycle();
    end
    @(negedge clk);
    check("to.rsp_valid", 64'(rsp_valid_rr), 64'(3'b100));
    check("to.rsp_err", 64'(rsp_err_rr), 64'(1));
    check("to.rsp_data", 64'(rsp_data_rr), 64'(0));
    $display("txn timeout: rsp_valid=%b err=%b", rsp_valid_rr, rsp_err_rr);
    next_cycle();
    ack_man = 1'b1;
    next_cycle();
    ack_man = 1'b0;
    @(negedge clk);
    check("to.late_ack", 64'(rsp_valid_rr), 64'(0));
    next_cycle();
`endif

    // Three-cycle intr pulse appears two cycles later for three cycles
    intr = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) intr = 1'b0;
      @(negedge clk);
      check($sformatf("intr[%0d]", c), 64'(intr_sync_rr), 64'(c >= 2 && c <= 4));
      $display("txn intr[%0d]: intr_sync=%b", c, intr_sync_rr);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
